instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage of the Risco-5 core. It issues word reads to instruction memory, buffers returned words with their PCs in a 2-entry FIFO, and presents them to decode, where the instruction word feeds the immediate generator and control decode. Branch/jump redirects from execute flush the buffer. A redirect that arrives while a memory read is outstanding is handled by draining the stale read.

## Interface
Parameters:
- `RESET_VECTOR`, 32'h0000_0000, first fetch address after reset
- `FIFO_DEPTH`, 2, buffer entries; must be a power of two and at least 2

Ports:
- `clk`  in  1  core clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `redirect_i`  in  1  flush and restart fetch at `redirect_pc_i`
- `redirect_pc_i`  in  32  redirect target
- `mem_req_o`  out  1  read request to instruction memory
- `mem_addr_o`  out  32  word address of the request
- `mem_ack_i`  in  1  request accepted; `mem_rdata_i` valid this cycle
- `mem_rdata_i`  in  32  instruction word
- `instr_valid_o`  out  1  FIFO head valid
- `instr_ready_i`  in  1  decode accepts head
- `instr_o`  out  32  head instruction
- `pc_o`  out  32  head PC
- `fault_o`  out  1  misaligned-redirect fault; see Configuration

## Operation
- The FSM has four states.
  - `BOOT`: the reset state.
  - `RUN`: normal fetching.
  - `DRAIN`: a stale request is outstanding.
  - `FAULT`: used only when alignment checking is enabled.
- Registers: `fetch_pc`, `pending_pc`, FIFO storage, read/write pointers, and a `count` of width log2(FIFO_DEPTH)+1.
- Memory protocol:
  - `mem_req_o` is held high with `mem_addr_o` stable until `mem_ack_i` is sampled high.
  - At most one request is outstanding.
  - A new request may start the cycle after an ack.
- Request rule:
  - In `RUN`, `mem_req_o` = FIFO not full.
  - In `DRAIN`, `mem_req_o` = 1.
  - In `BOOT` and `FAULT`, `mem_req_o` = 0.
  - A raised request never drops before its ack, because `count` rises only on acks.
- `mem_addr_o` is `fetch_pc` in `RUN` and the stale address in `DRAIN`.
- Ack in `RUN` without redirect:
  - Push {`mem_rdata_i`, `fetch_pc`} into the FIFO.
  - `fetch_pc` += 4, wrapping modulo 2^32.
- Pop occurs when `instr_valid_o` & `instr_ready_i`. Push and pop in the same cycle leave `count` unchanged.
- `instr_valid_o` = `count` != 0. `instr_o` and `pc_o` are the FIFO head.
- Redirect has priority over push and pop. In the cycle `redirect_i`=1:
  - The FIFO is cleared (`count`=0 next cycle).
  - Any ack that cycle is discarded.
  - `fetch_pc` ← `redirect_pc_i`.
- Redirect while `mem_req_o`=1 and `mem_ack_i`=0:
  - `pending_pc` ← `redirect_pc_i`; go to `DRAIN`.
  - In `DRAIN`, the ack is discarded, then `fetch_pc` ← `pending_pc` and the FSM goes to `RUN`.
- Redirect while in `DRAIN`: `pending_pc` ← new target; the FSM stays in `DRAIN`.
- Redirect with ack in the same cycle: data is discarded and the FSM goes straight to `RUN` at the new PC.

## Timing
- Reset values:
  - `mem_req_o`=0, `mem_addr_o`=RESET_VECTOR.
  - `instr_valid_o`=0, `instr_o`=0, `pc_o`=0.
  - `fault_o`=0.
  - State `BOOT`, `count`=0.
- The first rising edge after `rst_n` deasserts moves `BOOT`→`RUN`. `mem_req_o` rises in that cycle.
- Ack in cycle N → `instr_valid_o`=1 in cycle N+1.
- With a zero-wait memory and `instr_ready_i`=1, throughput is 1 instruction per cycle.
- Redirect in cycle N:
  - `instr_valid_o`=0 in N+1.
  - Request to the new target starts in N+1, or in the cycle after the stale ack when draining.
- Reset asserted mid-request drops `mem_req_o` asynchronously. Memory must tolerate an abandoned request.

## Configuration
- Macro `IFETCH_ALIGN_CHECK_EN` controls misaligned-redirect handling.
- Defined:
  - A redirect with `redirect_pc_i[1:0]`!=0 clears the FIFO and enters `FAULT`; a pending drain completes first.
  - In `FAULT`: no requests, `fault_o`=1.
  - The next aligned redirect clears `fault_o` and resumes `RUN`.
  - A misaligned redirect while in `FAULT` keeps the fault.
- Undefined:
  - `redirect_pc_i[1:0]` is forced to 00.
  - `FAULT` is unreachable and `fault_o` is tied 0.

## Test plan
- Reset release, zero-wait memory returning addr^32'hA5A5_0000, ready=1 → requests at 0x0, 0x4, 0x8 on consecutive cycles; outputs pc 0x0/instr 0xA5A5_0000, then pc 0x4, with no gaps.
- ready=0 for 5 cycles → exactly 2 entries buffered (pc 0x0, 0x4), `mem_req_o`=0 while full; ready=1 pops in order and `mem_req_o` reasserts the next cycle.
- Memory with 3-cycle ack latency, redirect to 0x100 in the first wait cycle → stale ack at 0x8 discarded, next request addr 0x100, first valid output pc 0x100.
- Redirect to 0x200 in the same cycle as ack and a pop with FIFO holding 2 entries → `instr_valid_o`=0 the next cycle, then pc 0x200; no stale pc appears.
- Redirect to 0x40, then to 0x80 while in `DRAIN` → first output pc 0x80; 0x40 is never fetched.
- With `IFETCH_ALIGN_CHECK_EN`, redirect to 0x102 → `fault_o`=1, `mem_req_o`=0 and `instr_valid_o`=0 for 10 cycles; redirect to 0x104 clears `fault_o` and the first output is pc 0x104. Without the macro, the same stimulus fetches pc 0x100.

Source files
------------

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - Risco-5 fetch stage: word reads, 2-entry PC/instr buffer, redirect drain
// Optional macro IFETCH_ALIGN_CHECK_EN enables misaligned-redirect faulting.
module instruction_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          FIFO_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        fault_o
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, DRAIN = 2'd2, FAULT = 2'd3} state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic [31:0]   pending_pc, pending_pc_nxt;
  logic          fault_pend, fault_pend_nxt;
  logic [31:0]   fifo_instr [FIFO_DEPTH];
  logic [31:0]   fifo_pc    [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          full, push, pop;
  logic [31:0]   tgt;
  logic          misaligned;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign tgt        = redirect_pc_i;
  assign misaligned = redirect_pc_i[1:0] != 2'b00;
  assign fault_o    = state == FAULT;
`else
  assign tgt        = redirect_pc_i & 32'hFFFF_FFFC;
  assign misaligned = 1'b0;
  assign fault_o    = 1'b0;
`endif

  assign full          = count == (AW+1)'(FIFO_DEPTH);
  assign instr_valid_o = count != '0;
  assign instr_o       = fifo_instr[rd_ptr];
  assign pc_o          = fifo_pc[rd_ptr];
  assign pop           = instr_valid_o & instr_ready_i & ~redirect_i;

  always_comb begin
    state_nxt      = state;
    fetch_pc_nxt   = fetch_pc;
    pending_pc_nxt = pending_pc;
    fault_pend_nxt = fault_pend;
    mem_req_o      = 1'b0;
    mem_addr_o     = fetch_pc;
    push           = 1'b0;
    case (state)
      BOOT: begin
        state_nxt = RUN;
        if (redirect_i) begin
          fetch_pc_nxt = tgt;
          if (misaligned) state_nxt = FAULT;
        end
      end
      RUN: begin
        mem_req_o = ~full;
        if (redirect_i) begin
          // An unacked request cannot be withdrawn; keep its address and drain it
          if (~full && !mem_ack_i) begin
            pending_pc_nxt = tgt;
            fault_pend_nxt = misaligned;
            state_nxt      = DRAIN;
          end else if (misaligned) begin
            state_nxt = FAULT;
          end else begin
            fetch_pc_nxt = tgt;
          end
        end else if (~full && mem_ack_i) begin
          push         = 1'b1;
          fetch_pc_nxt = fetch_pc + 32'd4;
        end
      end
      DRAIN: begin
        mem_req_o = 1'b1;
        if (redirect_i) begin
          pending_pc_nxt = tgt;
          fault_pend_nxt = misaligned;
        end
        if (mem_ack_i) begin
          fetch_pc_nxt = redirect_i ? tgt : pending_pc;
          state_nxt    = (redirect_i ? misaligned : fault_pend) ? FAULT : RUN;
        end
      end
      FAULT: begin
        if (redirect_i && !misaligned) begin
          fetch_pc_nxt = tgt;
          state_nxt    = RUN;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      fetch_pc   <= RESET_VECTOR;
      pending_pc <= RESET_VECTOR;
      fault_pend <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else begin
      state      <= state_nxt;
      fetch_pc   <= fetch_pc_nxt;
      pending_pc <= pending_pc_nxt;
      fault_pend <= fault_pend_nxt;
      if (redirect_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else if (push) begin
      fifo_instr[wr_ptr] <= mem_rdata_i;
      fifo_pc[wr_ptr]    <= fetch_pc;
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard bench for instruction_fetch with random memory latency
module tb_instruction_fetch;
  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] K  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        fault_o;

  instruction_fetch #(.RESET_VECTOR(RV), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .pc_o(pc_o), .fault_o(fault_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp_q[$];
  logic [31:0] ack_addr_q[$];
  int          ack_cyc_q[$];
  int          hs_cyc_q[$];
  int          hs_total = 0;
  int          lat_mode = 0;
  int          mem_cnt = 0;
  int          mem_lat = 0;
  logic        prev_pend = 1'b0;
  logic [31:0] prev_addr = '0;
  int          c0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected stream: consecutive word PCs from the last effective redirect target
  function automatic void sb_fill();
    while (exp_q.size() < 16) exp_q.push_back(exp_q[$] + 32'd4);
  endfunction

  function automatic void sb_restart(input logic [31:0] pc);
    exp_q.delete();
    exp_q.push_back(pc);
    sb_fill();
  endfunction

  function automatic void sb_redirect(input logic [31:0] pc);
`ifdef IFETCH_ALIGN_CHECK_EN
    if (pc[1:0] != 2'b00) exp_q.delete();
    else sb_restart(pc);
`else
    sb_restart(pc & 32'hFFFF_FFFC);
`endif
  endfunction

  // Memory model: acks after mem_lat wait cycles, returns addr ^ K, checks request hold
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pend = 1'b0;
      mem_cnt   = 0;
      mem_ack_i = 1'b0;
    end else begin
      if (prev_pend) begin
        checks++;
        if (!mem_req_o || mem_addr_o !== prev_addr) begin
          failures++;
          $display("FAIL mem_hold: got req %b addr %h expected req 1 addr %h", mem_req_o, mem_addr_o, prev_addr);
        end
      end
      if (mem_req_o) begin
        if (!prev_pend) mem_lat = (lat_mode < 0) ? $urandom_range(0, 3) : lat_mode;
        if (mem_cnt >= mem_lat) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = mem_addr_o ^ K;
          ack_addr_q.push_back(mem_addr_o);
          ack_cyc_q.push_back(cyc);
          mem_cnt   = 0;
          prev_pend = 1'b0;
        end else begin
          mem_ack_i   = 1'b0;
          mem_rdata_i = $urandom;
          mem_cnt++;
          prev_pend = 1'b1;
          prev_addr = mem_addr_o;
        end
      end else begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = $urandom;
        mem_cnt     = 0;
        prev_pend   = 1'b0;
      end
    end
  end

  // Monitor: every accepted instruction is popped against the expected stream
  always @(negedge clk) begin
    if (rst_n && instr_valid_o && instr_ready_i && !redirect_i) begin
      hs_cyc_q.push_back(cyc);
      hs_total++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got pc %h expected no output", pc_o);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("sb_pc", pc_o, e);
        chk("sb_instr", instr_o, e ^ K);
        sb_fill();
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_i    = 1'b1;
    redirect_pc_i = pc;
    sb_redirect(pc);
    step();
    redirect_i    = 1'b0;
    redirect_pc_i = $urandom;
  endtask

  task automatic do_reset();
    step();
    rst_n      = 1'b0;
    redirect_i = 1'b0;
    #1;
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_addr", mem_addr_o, RV);
    chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_fault", {31'd0, fault_o}, 32'd0);
    step();
    step();
    sb_restart(RV);
    ack_addr_q.delete();
    ack_cyc_q.delete();
    hs_cyc_q.delete();
    c0    = cyc;
    rst_n = 1'b1;
  endtask

  initial begin
    int found;
    int n40;
    int hs0;

    // Zero-wait streaming from reset
    lat_mode = 0;
    instr_ready_i = 1'b1;
    do_reset();
    repeat (8) step();
    if (ack_addr_q.size() < 3 || hs_cyc_q.size() < 3) begin
      checks++; failures++;
      $display("FAIL stream_len: got acks %0d outputs %0d expected at least 3", ack_addr_q.size(), hs_cyc_q.size());
    end else begin
      chk("first_req_cycle", ack_cyc_q[0], c0 + 1);
      chk("req0_addr", ack_addr_q[0], 32'h0);
      chk("req1_addr", ack_addr_q[1], 32'h4);
      chk("req2_addr", ack_addr_q[2], 32'h8);
      chk("req_back_to_back", ack_cyc_q[2] - ack_cyc_q[0], 2);
      chk("ack_to_valid", hs_cyc_q[0], ack_cyc_q[0] + 1);
      chk("out_no_gaps", hs_cyc_q[2] - hs_cyc_q[0], 2);
    end

    // Back-pressure fills exactly two entries
    instr_ready_i = 1'b0;
    do_reset();
    repeat (6) step();
    chk("full_req_low", {31'd0, mem_req_o}, 32'd0);
    chk("full_valid", {31'd0, instr_valid_o}, 32'd1);
    chk("full_head_pc", pc_o, 32'h0);
    chk("full_entries", ack_addr_q.size(), 2);
    instr_ready_i = 1'b1;
    step();
    chk("req_reassert", {31'd0, mem_req_o}, 32'd1);
    repeat (4) step();

    // Redirect during a slow request drains the stale read
    lat_mode = 2;
    do_reset();
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      if (mem_req_o && mem_addr_o == 32'h8) found = 1;
      else step();
    end
    chk("found_req8", found, 1);
    ack_addr_q.delete();
    hs0 = hs_total;
    redirect_to(32'h100);
    repeat (12) step();
    if (ack_addr_q.size() < 2) begin
      checks++; failures++;
      $display("FAIL drain_acks: got %0d acks expected at least 2", ack_addr_q.size());
    end else begin
      chk("stale_ack_addr", ack_addr_q[0], 32'h8);
      chk("new_req_addr", ack_addr_q[1], 32'h100);
    end
    chk("drain_progress", {31'd0, hs_total > hs0}, 32'd1);

    // Redirect concurrent with a pop on a full buffer
    lat_mode = 0;
    instr_ready_i = 1'b0;
    do_reset();
    repeat (6) step();
    instr_ready_i = 1'b1;
    redirect_to(32'h200);
    chk("flush_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("flush_req", {31'd0, mem_req_o}, 32'd1);
    chk("flush_addr", mem_addr_o, 32'h200);
    repeat (4) step();

    // Re-redirect while draining
    lat_mode = 3;
    do_reset();
    for (int i = 0; i < 10 && !mem_req_o; i++) step();
    ack_addr_q.delete();
    redirect_to(32'h40);
    redirect_to(32'h80);
    repeat (15) step();
    n40 = 0;
    foreach (ack_addr_q[i]) if (ack_addr_q[i] == 32'h40) n40++;
    chk("no_fetch_0x40", n40, 0);
    if (ack_addr_q.size() >= 2) chk("redrain_addr", ack_addr_q[1], 32'h80);
    else begin
      checks++; failures++;
      $display("FAIL redrain_acks: got %0d acks expected at least 2", ack_addr_q.size());
    end

    // Misaligned redirect
    lat_mode = 0;
    do_reset();
    repeat (3) step();
    redirect_to(32'h102);
`ifdef IFETCH_ALIGN_CHECK_EN
    for (int i = 0; i < 10; i++) begin
      chk("fault_hold", {29'd0, fault_o, mem_req_o, instr_valid_o}, 32'b100);
      step();
    end
    redirect_to(32'h104);
    chk("fault_clear", {31'd0, fault_o}, 32'd0);
`else
    for (int i = 0; i < 3; i++) begin
      chk("no_fault", {31'd0, fault_o}, 32'd0);
      step();
    end
`endif
    repeat (5) step();

    // Address wrap
    redirect_to(32'hFFFF_FFF8);
    repeat (6) step();

    // Random traffic
    lat_mode = -1;
    hs0 = hs_total;
    for (int i = 0; i < 3000; i++) begin
      instr_ready_i = ($urandom_range(0, 3) != 0);
      if (fault_o) chk("fault_quiet", {30'd0, mem_req_o, instr_valid_o}, 32'd0);
      if ($urandom_range(0, 24) == 0) begin
        case ($urandom_range(0, 9))
          0:       redirect_to(($urandom & 32'h0000_0FFC) | 32'h2);
          1:       redirect_to(32'hFFFF_FFF0);
          default: redirect_to($urandom & 32'h0000_0FFC);
        endcase
      end else begin
        step();
      end
    end
    chk("random_progress", {31'd0, (hs_total - hs0) > 500}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no completion expected finish before 1ms");
    $fatal(1, "timeout");
  end
endmodule
